// File: rtl/msx_cart_bus_bridge.sv
// MSX cartridge slot front end: turns each slot read/write into a single VDP host-port transaction.
// Wait-state output (twait) is generated only when MSX_BRIDGE_TWAIT_EN is defined.
module msx_cart_bus_bridge #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       n_ce,
    input  logic       n_trd,
    input  logic       n_twr,
    input  logic [1:0] ta,
    input  logic [7:0] td_in,
    output logic [7:0] td_out,
    output logic       tdir,
    output logic       twait,
    output logic       req,
    input  logic       ack,
    output logic       wr,
    output logic [1:0] address,
    output logic [7:0] wdata,
    input  logic [7:0] rdata
);

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RD   = 2'd1,
        ACC_WR   = 2'd2
    } acc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [2:0] STABLE_L = 3'(STABLE_CYCLES);
    localparam logic [2:0] SYNC_L   = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d;
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0] wrn_sync_q, wrn_sync_d;

    logic ce_s, rd_s, wr_n_s;
    acc_t acc_s;
    acc_t acc_prev_q, acc_prev_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] flush_q, flush_d;
    logic seen_idle_q, seen_idle_d;
    logic accept_s;

    state_t state_q, state_d;
    logic       req_q, req_d;
    logic       wr_q, wr_d;
    logic [1:0] address_q, address_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] td_out_q, td_out_d;
    logic       tdir_q, tdir_d;
    logic       released_q, released_d;
    acc_t       cur_type_s;
    logic       rel_now_s;

    // synchronizer shift inputs
    always_comb begin
        ce_sync_d  = {ce_sync_q[SYNC_STAGES-2:0], n_ce};
        rd_sync_d  = {rd_sync_q[SYNC_STAGES-2:0], n_trd};
        wrn_sync_d = {wrn_sync_q[SYNC_STAGES-2:0], n_twr};
    end

    assign ce_s   = ce_sync_q[SYNC_STAGES-1];
    assign rd_s   = rd_sync_q[SYNC_STAGES-1];
    assign wr_n_s = wrn_sync_q[SYNC_STAGES-1];

    // access decode; both strobes low is illegal and decodes as no access
    always_comb begin
        acc_s = ACC_NONE;
        if (!ce_s && !rd_s && wr_n_s) begin
            acc_s = ACC_RD;
        end else if (!ce_s && !wr_n_s && rd_s) begin
            acc_s = ACC_WR;
        end else begin
            acc_s = ACC_NONE;
        end
    end

    // stability filter and post-reset release tracking
    always_comb begin
        acc_prev_d  = acc_s;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        seen_idle_d = seen_idle_q;
        if (acc_s != acc_prev_q) begin
            cnt_d = 3'd0;
        end else if (cnt_q != STABLE_L) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = cnt_q;
        end
        // synchronizer outputs only reflect the pins once the reset ones have flushed out
        if (flush_q != SYNC_L) begin
            flush_d = flush_q + 3'd1;
        end else begin
            flush_d = flush_q;
        end
        if ((flush_q == SYNC_L) && (acc_s == ACC_NONE)) begin
            seen_idle_d = 1'b1;
        end else begin
            seen_idle_d = seen_idle_q;
        end
        accept_s = seen_idle_q && (acc_s != ACC_NONE) && (cnt_d == STABLE_L);
    end

    assign cur_type_s = wr_q ? ACC_WR : ACC_RD;
    assign rel_now_s  = released_q || (acc_s != cur_type_s);

    // transaction state machine, next state and registered outputs
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wr_d       = wr_q;
        address_d  = address_q;
        wdata_d    = wdata_q;
        td_out_d   = td_out_q;
        tdir_d     = tdir_q;
        released_d = released_q;
        case (state_q)
            ST_IDLE: begin
                tdir_d     = 1'b0;
                released_d = 1'b0;
                if (accept_s) begin
                    req_d     = 1'b1;
                    address_d = ta;
                    if (acc_s == ACC_WR) begin
                        wr_d    = 1'b1;
                        wdata_d = td_in;
                    end else begin
                        wr_d    = 1'b0;
                        wdata_d = wdata_q;
                    end
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    req_d      = 1'b0;
                    released_d = 1'b0;
                    // a request is never withdrawn; a released access just drops its read data
                    if (rel_now_s) begin
                        tdir_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (!wr_q) begin
                        td_out_d = rdata;
                        tdir_d   = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        tdir_d  = 1'b0;
                        state_d = ST_HOLD;
                    end
                end else begin
                    released_d = rel_now_s;
                    state_d    = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (acc_s != cur_type_s) begin
                    tdir_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tdir_d  = !wr_q;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                tdir_d  = 1'b0;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_sync_q   <= {SYNC_STAGES{1'b1}};
            rd_sync_q   <= {SYNC_STAGES{1'b1}};
            wrn_sync_q  <= {SYNC_STAGES{1'b1}};
            acc_prev_q  <= ACC_NONE;
            cnt_q       <= 3'd0;
            flush_q     <= 3'd0;
            seen_idle_q <= 1'b0;
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            address_q   <= 2'd0;
            wdata_q     <= 8'd0;
            td_out_q    <= 8'd0;
            tdir_q      <= 1'b0;
            released_q  <= 1'b0;
        end else begin
            ce_sync_q   <= ce_sync_d;
            rd_sync_q   <= rd_sync_d;
            wrn_sync_q  <= wrn_sync_d;
            acc_prev_q  <= acc_prev_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            seen_idle_q <= seen_idle_d;
            state_q     <= state_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            td_out_q    <= td_out_d;
            tdir_q      <= tdir_d;
            released_q  <= released_d;
        end
    end

`ifdef MSX_BRIDGE_TWAIT_EN
    logic twait_q, twait_d;

    // wait request rises with acceptance and falls on the edge after ack
    always_comb begin
        twait_d = twait_q;
        if ((state_q == ST_IDLE) && accept_s) begin
            twait_d = 1'b1;
        end else if ((state_q == ST_REQ) && ack) begin
            twait_d = 1'b0;
        end else begin
            twait_d = twait_q;
        end
    end

    // wait-state register
    always_ff @(posedge clk) begin
        if (reset) begin
            twait_q <= 1'b0;
        end else begin
            twait_q <= twait_d;
        end
    end

    assign twait = twait_q;
`else
    assign twait = 1'b0;
`endif

    assign req     = req_q;
    assign wr      = wr_q;
    assign address = address_q;
    assign wdata   = wdata_q;
    assign td_out  = td_out_q;
    assign tdir    = tdir_q;

endmodule

// File: tb/tb_msx_cart_bus_bridge.sv
// Self-checking bench for msx_cart_bus_bridge: vector table, scoreboard of expected requests,
// and hand-written early-release and reset-in-REQ sequences.
module tb_msx_cart_bus_bridge;

    localparam int SYNC   = 2;
    localparam int STABLE = 2;

    logic       clk;
    logic       reset;
    logic       n_ce, n_trd, n_twr;
    logic [1:0] ta;
    logic [7:0] td_in;
    logic [7:0] td_out;
    logic       tdir, twait, req, ack, wr;
    logic [1:0] address;
    logic [7:0] wdata;
    logic [7:0] rdata;

    msx_cart_bus_bridge #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .reset(reset), .n_ce(n_ce), .n_trd(n_trd), .n_twr(n_twr),
        .ta(ta), .td_in(td_in), .td_out(td_out), .tdir(tdir), .twait(twait),
        .req(req), .ack(ack), .wr(wr), .address(address), .wdata(wdata), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
    } txn_t;

    typedef struct {
        logic       is_wr;
        logic       both;
        logic [1:0] ta;
        logic [7:0] td;
        logic [7:0] rd;
        int         low_cyc;
        int         ack_dly;
        int         gap;
        logic       exp_req;
        logic       exp_tdir;
    } vec_t;

    txn_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   req_pulses = 0;
    int   ack_dly_g = 0;
    logic [7:0] rdata_g = 8'h00;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // VDP model: acks ack_dly_g cycles after seeing req, returning rdata_g
    initial begin
        ack = 1'b0;
        rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en && (req === 1'b1)) begin
                repeat (ack_dly_g) @(negedge clk);
                ack = 1'b1;
                rdata = rdata_g;
                @(negedge clk);
                ack = 1'b0;
                rdata = 8'h00;
            end
        end
    end

    // scoreboard monitor: every new request must match the oldest expected transaction
    initial begin
        logic req_prev;
        txn_t t;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
`ifdef MSX_BRIDGE_TWAIT_EN
                check("twait_tracks_req", {31'd0, twait}, {31'd0, req});
`else
                check("twait_tied_low", {31'd0, twait}, 32'd0);
`endif
                if (req && !req_prev) begin
                    req_pulses++;
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_req: got req=1 wr=%0d addr=%0d, required no request", wr, address);
                    end else begin
                        t = sb.pop_front();
                        check("req_wr", {31'd0, wr}, {31'd0, t.wr});
                        check("req_addr", {30'd0, address}, {30'd0, t.addr});
                        if (t.wr) check("req_wdata", {24'd0, wdata}, {24'd0, t.data});
                    end
                end
                req_prev = req;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic settle_req();
        for (int c = 0; c < 60 && req; c++) @(negedge clk);
        check("req_settle", {31'd0, req}, 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        vec_t v;
        int   p0, rel_cnt;
        logic tdir_seen, tdir_drop;
        logic [7:0] td_seen;

        vecs[0] = '{1'b1, 1'b0, 2'd1, 8'h8F, 8'h00, 40, 3, 8, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 8'h00, 8'h5A, 40, 3, 8, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 8'h33, 8'h00, 1, 0, 8, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 20, 0, 8, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 2'd2, 8'h44, 8'h00, STABLE, 0, 8, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 8'hC3, 8'h00, STABLE + 1, 1, 15, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 2'd2, 8'h00, 8'hA5, 30, 0, 8, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 2'd0, 8'h11, 8'h00, 20, 0, 4, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 2'd1, 8'h22, 8'h00, 20, 2, 8, 1'b1, 1'b0};

        reset = 1'b1;
        n_ce = 1'b1; n_trd = 1'b1; n_twr = 1'b1;
        ta = 2'd0; td_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_wr", {31'd0, wr}, 32'd0);
        check("rst_addr", {30'd0, address}, 32'd0);
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        check("rst_td_out", {24'd0, td_out}, 32'd0);
        check("rst_tdir", {31'd0, tdir}, 32'd0);
        check("rst_twait", {31'd0, twait}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            ack_dly_g = v.ack_dly;
            rdata_g = v.rd;
            if (v.exp_req) sb.push_back(txn_t'{v.is_wr, v.ta, v.td});
            p0 = req_pulses;
            ta = v.ta; td_in = v.td; n_ce = 1'b0;
            if (v.both) begin
                n_trd = 1'b0; n_twr = 1'b0;
            end else if (v.is_wr) begin
                n_twr = 1'b0;
            end else begin
                n_trd = 1'b0;
            end
            tdir_seen = 1'b0; tdir_drop = 1'b0; td_seen = 8'h00;
            for (int c = 0; c < v.low_cyc; c++) begin
                @(negedge clk);
                if (tdir) begin
                    tdir_seen = 1'b1;
                    td_seen = td_out;
                end else if (tdir_seen) begin
                    tdir_drop = 1'b1;
                end
            end
            n_ce = 1'b1; n_trd = 1'b1; n_twr = 1'b1;
            rel_cnt = 0;
            while (tdir && rel_cnt < 10) begin
                @(negedge clk);
                rel_cnt++;
            end
            for (int c = 0; c < v.gap; c++) begin
                @(negedge clk);
                if (tdir) tdir_seen = 1'b1;
            end
            settle_req();
            check($sformatf("v%0d_req_count", i), req_pulses - p0, {31'd0, v.exp_req});
            check($sformatf("v%0d_tdir_seen", i), {31'd0, tdir_seen}, {31'd0, v.exp_tdir});
            if (v.exp_tdir) begin
                check($sformatf("v%0d_td_out", i), {24'd0, td_seen}, {24'd0, v.rd});
                check($sformatf("v%0d_tdir_held", i), {31'd0, tdir_drop}, 32'd0);
                check($sformatf("v%0d_tdir_release", i), {31'd0, (rel_cnt <= SYNC + 1)}, 32'd1);
            end
        end

        // early release: read strobe lifted while req is pending, ack 10 clk later
        ack_dly_g = 10;
        rdata_g = 8'hEE;
        sb.push_back(txn_t'{1'b0, 2'd3, 8'h00});
        p0 = req_pulses;
        ta = 2'd3; n_ce = 1'b0; n_trd = 1'b0;
        for (int c = 0; c < 30 && !req; c++) @(negedge clk);
        check("early_req_seen", {31'd0, req}, 32'd1);
        n_ce = 1'b1; n_trd = 1'b1;
        tdir_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tdir) tdir_seen = 1'b1;
        end
        check("early_req_count", req_pulses - p0, 32'd1);
        check("early_req_dropped", {31'd0, req}, 32'd0);
        check("early_tdir_never", {31'd0, tdir_seen}, 32'd0);
        check("early_td_out_kept", {24'd0, td_out}, 32'h0000_00A5);

        // reset while req is pending with the strobes held low
        ack_dly_g = 40;
        sb.push_back(txn_t'{1'b1, 2'd2, 8'h77});
        p0 = req_pulses;
        ta = 2'd2; td_in = 8'h77; n_ce = 1'b0; n_twr = 1'b0;
        for (int c = 0; c < 30 && !req; c++) @(negedge clk);
        check("rreq_req_seen", {31'd0, req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rreq_req", {31'd0, req}, 32'd0);
        check("rreq_wr", {31'd0, wr}, 32'd0);
        check("rreq_addr", {30'd0, address}, 32'd0);
        check("rreq_wdata", {24'd0, wdata}, 32'd0);
        check("rreq_td_out", {24'd0, td_out}, 32'd0);
        check("rreq_tdir", {31'd0, tdir}, 32'd0);
        check("rreq_twait", {31'd0, twait}, 32'd0);
        repeat (50) @(negedge clk);
        check("rreq_no_retrigger", req_pulses - p0, 32'd1);
        n_ce = 1'b1; n_twr = 1'b1;
        repeat (5) @(negedge clk);
        ack_dly_g = 2;
        sb.push_back(txn_t'{1'b1, 2'd2, 8'h77});
        n_ce = 1'b0; n_twr = 1'b0;
        repeat (20) @(negedge clk);
        n_ce = 1'b1; n_twr = 1'b1;
        repeat (8) @(negedge clk);
        settle_req();
        check("rreq_reaccess", req_pulses - p0, 32'd2);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
